// File: rtl/mem_block_engine.sv
// Block COPY / FILL / COMPARE engine that masters a combinational-read,
// clocked-write word memory. State is exposed on dbg_state for checkers.
module mem_block_engine #(
  parameter int BITSIZE = 32,
  parameter int MEMSIZE = 64,
  localparam int AW = $clog2(MEMSIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [AW-1:0]      src_addr,
  input  logic [AW-1:0]      dst_addr,
  input  logic [AW:0]        length,
  input  logic [BITSIZE-1:0] fill_data,
  output logic               busy,
  output logic               done,
  output logic [AW:0]        mismatch_count,
  output logic [AW-1:0]      first_mismatch,
  output logic [AW-1:0]      mem_addr,
  output logic [BITSIZE-1:0] mem_wdata,
  output logic               mem_read,
  output logic               mem_write,
  input  logic [BITSIZE-1:0] mem_rdata,
  output logic [2:0]         dbg_state
);

  // Handshake: start is only sampled in IDLE; busy is high from the cycle
  // after an accepted start through FINISH, and done pulses in that FINISH
  // cycle. No backpressure: the memory accepts every strobe in its cycle.

  localparam logic [1:0] OP_COPY    = 2'b00;
  localparam logic [1:0] OP_FILL    = 2'b01;
  localparam logic [1:0] OP_COMPARE = 2'b10;
  localparam logic [1:0] OP_NOP     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_SRC = 3'd1,
    S_RD_DST = 3'd2,
    S_WR     = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         op_reg;
  logic [AW-1:0]      src_reg, dst_reg;
  logic [AW:0]        len_reg;
  logic [BITSIZE-1:0] fill_reg, data_reg;
  logic [AW:0]        idx, idx_inc;
  logic               last_word;

  assign idx_inc   = idx + 1'b1;
  assign last_word = (idx_inc == len_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      op_reg         <= '0;
      src_reg        <= '0;
      dst_reg        <= '0;
      len_reg        <= '0;
      fill_reg       <= '0;
      data_reg       <= '0;
      idx            <= '0;
      mismatch_count <= '0;
      first_mismatch <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_reg         <= op;
            src_reg        <= src_addr;
            dst_reg        <= dst_addr;
            len_reg        <= length;
            fill_reg       <= fill_data;
            idx            <= '0;
            mismatch_count <= '0;
            first_mismatch <= '0;
          end
        end
        S_RD_SRC: data_reg <= mem_rdata;
        S_RD_DST: begin
          if (mem_rdata != data_reg) begin
            mismatch_count <= mismatch_count + 1'b1;
            if (mismatch_count == '0) first_mismatch <= idx[AW-1:0];
          end
          idx <= idx_inc;
        end
        S_WR: idx <= idx_inc;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (length == '0 || op == OP_NOP) state_nxt = S_FINISH;
          else if (op == OP_FILL)           state_nxt = S_WR;
          else                              state_nxt = S_RD_SRC;
        end
      end
      S_RD_SRC: begin
        mem_addr  = src_reg + idx[AW-1:0];
        mem_read  = 1'b1;
        state_nxt = (op_reg == OP_COMPARE) ? S_RD_DST : S_WR;
      end
      S_RD_DST: begin
        mem_addr  = dst_reg + idx[AW-1:0];
        mem_read  = 1'b1;
        state_nxt = last_word ? S_FINISH : S_RD_SRC;
      end
      S_WR: begin
        mem_addr  = dst_reg + idx[AW-1:0];
        mem_write = 1'b1;
        mem_wdata = (op_reg == OP_FILL) ? fill_reg : data_reg;
        if (last_word)              state_nxt = S_FINISH;
        else if (op_reg == OP_COPY) state_nxt = S_RD_SRC;
        else                        state_nxt = S_WR;
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FINISH);
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_block_engine.sv
// Directed bench for mem_block_engine: a vector table of block operations
// against a 64-word memory model, plus mid-operation start and reset sequences.
module tb_mem_block_engine;

  localparam int BW = 32;
  localparam int MS = 64;
  localparam int AW = 6;

  localparam logic [1:0] OP_COPY = 2'b00;
  localparam logic [1:0] OP_FILL = 2'b01;
  localparam logic [1:0] OP_CMP  = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  logic          clk, rst, start;
  logic [1:0]    op;
  logic [AW-1:0] src_addr, dst_addr;
  logic [AW:0]   length;
  logic [BW-1:0] fill_data;
  logic          busy, done;
  logic [AW:0]   mismatch_count;
  logic [AW-1:0] first_mismatch;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_wdata, mem_rdata;
  logic          mem_read, mem_write;
  logic [2:0]    dbg_state;

  mem_block_engine #(.BITSIZE(BW), .MEMSIZE(MS)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_data(fill_data), .busy(busy), .done(done),
    .mismatch_count(mismatch_count), .first_mismatch(first_mismatch),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // memory model with a bench-side init/poke port
  logic [BW-1:0] mem [MS];
  logic          mem_init, poke_en;
  logic [AW-1:0] poke_addr;
  logic [BW-1:0] poke_val;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MS; i++) mem[i] <= BW'(i);
    end else if (poke_en) begin
      mem[poke_addr] <= poke_val;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // strobe monitor
  int rd_cnt  = 0;
  int wr_cnt  = 0;
  int bad_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (mem_read)  rd_cnt++;
      if (mem_write) wr_cnt++;
      if (mem_read && mem_write) bad_cnt++;
      if (!mem_write && mem_wdata != '0) bad_cnt++;
    end
  end

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [BW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_args(input logic [1:0] o, input logic [AW-1:0] s,
                            input logic [AW-1:0] d, input logic [AW:0] l,
                            input logic [BW-1:0] f);
    op = o; src_addr = s; dst_addr = d; length = l; fill_data = f;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [BW-1:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_val = v;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // counts cycles after the accepting edge until done; -1 on timeout
  task automatic wait_done(input int c0, output int lat, output int bcnt);
    lat = -1;
    bcnt = 0;
    for (int c = c0 + 1; c <= c0 + 300; c++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [AW-1:0] s,
                        input logic [AW-1:0] d, input logic [AW:0] l,
                        input logic [BW-1:0] f, output int lat, output int bcnt);
    @(negedge clk);
    drive_args(o, s, d, l, f);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(0, lat, bcnt);
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW:0]   len;
    logic [BW-1:0] fill;
    logic          poke;
    logic [AW-1:0] poke_addr;
    logic [BW-1:0] poke_val;
    int            exp_lat;
    int            exp_rd;
    int            exp_wr;
    logic [AW:0]   exp_mc;
    logic [AW-1:0] exp_fm;
    logic [AW-1:0] chk_addr;
    logic [BW-1:0] chk_val;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  initial begin
    int lat, bcnt, rd0, wr0, bad0;
    vec_t v;

    // memory starts as mem[i] = i; table entries build on each other
    vecs[0] = '{OP_COPY, 6'd0,  6'd32, 7'd4,  32'h0,        1'b0, 6'd0,  32'h0,  9,   4,   4, 7'd0, 6'd0, 6'd35, 32'd3};
    vecs[1] = '{OP_CMP,  6'd0,  6'd32, 7'd4,  32'h0,        1'b0, 6'd0,  32'h0,  9,   8,   0, 7'd0, 6'd0, 6'd33, 32'd1};
    vecs[2] = '{OP_CMP,  6'd0,  6'd32, 7'd4,  32'h0,        1'b1, 6'd34, 32'hFF, 9,   8,   0, 7'd1, 6'd2, 6'd34, 32'hFF};
    vecs[3] = '{OP_CMP,  6'd0,  6'd32, 7'd4,  32'h0,        1'b1, 6'd35, 32'hFF, 9,   8,   0, 7'd2, 6'd2, 6'd32, 32'd0};
    vecs[4] = '{OP_FILL, 6'd0,  6'd62, 7'd4,  32'hDEADBEEF, 1'b0, 6'd0,  32'h0,  5,   0,   4, 7'd0, 6'd0, 6'd1,  32'hDEADBEEF};
    vecs[5] = '{OP_COPY, 6'd0,  6'd2,  7'd0,  32'h0,        1'b0, 6'd0,  32'h0,  1,   0,   0, 7'd0, 6'd0, 6'd2,  32'd2};
    vecs[6] = '{OP_NOP,  6'd0,  6'd0,  7'd5,  32'h77,       1'b0, 6'd0,  32'h0,  1,   0,   0, 7'd0, 6'd0, 6'd0,  32'hDEADBEEF};
    vecs[7] = '{OP_CMP,  6'd0,  6'd1,  7'd3,  32'h0,        1'b0, 6'd0,  32'h0,  7,   6,   0, 7'd2, 6'd1, 6'd63, 32'hDEADBEEF};
    vecs[8] = '{OP_COPY, 6'd40, 6'd41, 7'd3,  32'h0,        1'b0, 6'd0,  32'h0,  7,   3,   3, 7'd0, 6'd0, 6'd43, 32'd40};
    vecs[9] = '{OP_CMP,  6'd5,  6'd5,  7'd64, 32'h0,        1'b0, 6'd0,  32'h0,  129, 128, 0, 7'd0, 6'd0, 6'd42, 32'd40};

    rst = 1'b0; start = 1'b0; mem_init = 1'b1; poke_en = 1'b0;
    poke_addr = '0; poke_val = '0;
    drive_args(OP_COPY, '0, '0, '0, '0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy",   64'(busy), 64'd0);
    chk("reset_done",   64'(done), 64'd0);
    chk("reset_rd_wr",  64'({mem_read, mem_write}), 64'd0);
    chk("reset_addr",   64'(mem_addr), 64'd0);
    chk("reset_wdata",  64'(mem_wdata), 64'd0);
    chk("reset_status", 64'({mismatch_count, first_mismatch}), 64'd0);
    chk("reset_state",  64'(dbg_state), 64'd0);
    @(negedge clk);
    mem_init = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      if (v.poke) poke(v.poke_addr, v.poke_val);
      rd0 = rd_cnt; wr0 = wr_cnt; bad0 = bad_cnt;
      run_op(v.op, v.src, v.dst, v.len, v.fill, lat, bcnt);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(v.exp_lat));
      chk($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'(v.exp_lat));
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), 64'({busy, done}), 64'd0);
      @(negedge clk);
      chk($sformatf("v%0d_reads", i), 64'(rd_cnt - rd0), 64'(v.exp_rd));
      chk($sformatf("v%0d_writes", i), 64'(wr_cnt - wr0), 64'(v.exp_wr));
      chk($sformatf("v%0d_strobe_rules", i), 64'(bad_cnt - bad0), 64'd0);
      chk($sformatf("v%0d_mismatch_count", i), 64'(mismatch_count), 64'(v.exp_mc));
      chk($sformatf("v%0d_first_mismatch", i), 64'(first_mismatch), 64'(v.exp_fm));
      exp_q.push_back(v.chk_val);
      chk($sformatf("v%0d_mem[%0d]", i, v.chk_addr), 64'(mem[v.chk_addr]), 64'(exp_q.pop_front()));
    end

    // start pulsed mid-COPY with other args, then held through FINISH into IDLE
    @(negedge clk);
    drive_args(OP_COPY, 6'd8, 6'd16, 7'd4, 32'h0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    drive_args(OP_FILL, 6'd0, 6'd20, 7'd2, 32'h55);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, lat, bcnt);
    chk("midstart_copy_latency", 64'(lat), 64'd9);
    start = 1'b1;
    @(negedge clk);
    chk("finish_start_ignored", 64'(busy), 64'd0);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(0, lat, bcnt);
    chk("after_done_fill_latency", 64'(lat), 64'd3);
    @(negedge clk);
    chk("midstart_mem16", 64'(mem[16]), 64'd8);
    chk("midstart_mem19", 64'(mem[19]), 64'd11);
    chk("after_done_mem20", 64'(mem[20]), 64'h55);
    chk("after_done_mem21", 64'(mem[21]), 64'h55);
    chk("after_done_mem22", 64'(mem[22]), 64'd22);

    // reset during WR of idx 3 in a length-8 FILL
    @(negedge clk);
    drive_args(OP_FILL, 6'd0, 6'd48, 7'd8, 32'hA5A5A5A5);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstfill_wr_active", 64'({mem_write, mem_addr}), 64'({1'b1, 6'd51}));
    rst = 1'b0;
    #1;
    chk("rstfill_write_drop", 64'(mem_write), 64'd0);
    chk("rstfill_busy_done", 64'({busy, done}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("rstfill_mem48", 64'(mem[48]), 64'hA5A5A5A5);
    chk("rstfill_mem50", 64'(mem[50]), 64'hA5A5A5A5);
    chk("rstfill_mem51", 64'(mem[51]), 64'd51);
    chk("rstfill_mem55", 64'(mem[55]), 64'd55);
    run_op(OP_FILL, 6'd0, 6'd51, 7'd1, 32'h1, lat, bcnt);
    chk("post_reset_latency", 64'(lat), 64'd2);
    @(negedge clk);
    chk("post_reset_mem51", 64'(mem[51]), 64'd1);
    chk("post_reset_mem52", 64'(mem[52]), 64'd52);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
